core_run_controller: RTL and testbench

CORE_RUN_CONTROLLER -- requirements
Module: core_run_controller

---
 rtl/core_run_pkg.sv | 14 +
 rtl/halt_detector.sv | 55 +++++
 rtl/core_run_controller.sv | 166 ++++++++++++++++
 tb/tb_core_run_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_run_pkg.sv
// Shared types and constants for the core run controller.
package core_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } run_state_e;

  localparam logic [31:0] ECALL_INSTR         = 32'h0000_0073;
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FFC;

endpackage

// File: rtl/halt_detector.sv
// Flags a self-loop halt once the PC has stayed unchanged for HALT_REPEAT
// consecutive enabled cycles. The first enabled cycle only loads prev_pc.
module halt_detector #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HALT_REPEAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] pc,
  output logic            halt
);

  localparam int unsigned RW = (HALT_REPEAT < 1) ? 1 : $clog2(HALT_REPEAT + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(HALT_REPEAT);

  logic [XLEN-1:0] prev_pc;
  logic            valid;
  logic [RW-1:0]   rpt;
  logic [RW-1:0]   rpt_d;

  // Next repeat count: saturating count of unchanged-PC cycles.
  always_comb begin
    rpt_d = rpt;
    if (pc == prev_pc) begin
      if (rpt != RPT_LAST) rpt_d = rpt + RW'(1);
    end else begin
      rpt_d = '0;
    end
  end

  // PC history and halt flag; cleared whenever detection is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pc <= '0;
      valid   <= 1'b0;
      rpt     <= '0;
      halt    <= 1'b0;
    end else if (!en) begin
      valid <= 1'b0;
      rpt   <= '0;
      halt  <= 1'b0;
    end else if (!valid) begin
      prev_pc <= pc;
      valid   <= 1'b1;
      rpt     <= '0;
      halt    <= 1'b0;
    end else begin
      prev_pc <= pc;
      rpt     <= rpt_d;
      halt    <= (rpt_d == RPT_LAST);
    end
  end

endmodule

// File: rtl/core_run_controller.sv
// Run controller for a test core: holds the core in reset, runs it, and
// detects termination via tohost write, ecall, self-loop or cycle budget.
module core_run_controller
  import core_run_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     RESET_CYCLES = 2,
  parameter int unsigned     MAX_CYCLES   = 1024,
  parameter int unsigned     HALT_REPEAT  = 3,
  parameter int unsigned     CNT_W        = 16,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(TOHOST_ADDR_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             core_rst_n,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [XLEN-1:0]  exit_code
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((RESET_CYCLES > 0) ? (RESET_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic              core_rst_n_d, running_d, done_d;
  logic              pass_d, fail_d, timeout_d;
  logic [CNT_W-1:0]  cycle_count_d;
  logic [XLEN-1:0]   exit_code_d;

  logic              launch, finish;
  logic              halt;
  logic              tohost_hit, ecall_hit, budget_hit;

  assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);
  assign ecall_hit  = (instr == ECALL_INSTR);
  assign budget_hit = (cycle_count == CNT_LAST);

  // Self-loop detection, active only while the core is running.
  halt_detector #(
    .XLEN        (XLEN),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detector (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_RUN),
    .pc   (pc),
    .halt (halt)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    core_rst_n_d  = core_rst_n;
    running_d     = running;
    done_d        = done;
    pass_d        = pass;
    fail_d        = fail;
    timeout_d     = timeout;
    cycle_count_d = cycle_count;
    exit_code_d   = exit_code;
    launch        = 1'b0;
    finish        = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        launch = start;
      end
      ST_RESET_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d      = ST_RUN;
          core_rst_n_d = 1'b1;
          running_d    = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (tohost_hit) begin
          finish      = 1'b1;
          exit_code_d = mem_wdata;
          pass_d      = (mem_wdata == XLEN'(1));
          fail_d      = (mem_wdata != XLEN'(1));
        end else if (ecall_hit || halt) begin
          finish      = 1'b1;
          exit_code_d = '0;
          pass_d      = 1'b1;
          fail_d      = 1'b0;
        end else if (budget_hit) begin
          finish      = 1'b1;
          exit_code_d = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b1;
          timeout_d   = 1'b1;
        end else if (cycle_count != '1) begin
          cycle_count_d = cycle_count + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (launch) begin
      state_d       = ST_RESET_HOLD;
      hold_d        = '0;
      core_rst_n_d  = 1'b0;
      running_d     = 1'b0;
      done_d        = 1'b0;
      pass_d        = 1'b0;
      fail_d        = 1'b0;
      timeout_d     = 1'b0;
      cycle_count_d = '0;
      exit_code_d   = '0;
    end

    if (finish) begin
      state_d      = ST_DONE;
      done_d       = 1'b1;
      running_d    = 1'b0;
      core_rst_n_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      core_rst_n  <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      exit_code   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      core_rst_n  <= core_rst_n_d;
      running     <= running_d;
      done        <= done_d;
      pass        <= pass_d;
      fail        <= fail_d;
      timeout     <= timeout_d;
      cycle_count <= cycle_count_d;
      exit_code   <= exit_code_d;
    end
  end

endmodule

// File: tb/tb_core_run_controller.sv
// Directed self-checking bench for core_run_controller.
module tb_core_run_controller;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  logic             clk;
  logic             rst;
  logic             start;
  logic [XLEN-1:0]  pc;
  logic [31:0]      instr;
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;

  logic             m_core_rst_n, m_running, m_done, m_pass, m_fail, m_timeout;
  logic [CNT_W-1:0] m_cc;
  logic [XLEN-1:0]  m_exit;

  logic             t_core_rst_n, t_running, t_done, t_pass, t_fail, t_timeout;
  logic [CNT_W-1:0] t_cc;
  logic [XLEN-1:0]  t_exit;

  int checks = 0;
  int errors = 0;

  core_run_controller dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc          (pc),
    .instr       (instr),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst_n  (m_core_rst_n),
    .running     (m_running),
    .done        (m_done),
    .pass        (m_pass),
    .fail        (m_fail),
    .timeout     (m_timeout),
    .cycle_count (m_cc),
    .exit_code   (m_exit)
  );

  core_run_controller #(.MAX_CYCLES(16)) dut_to (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc          (pc),
    .instr       (instr),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst_n  (t_core_rst_n),
    .running     (t_running),
    .done        (t_done),
    .pass        (t_pass),
    .fail        (t_fail),
    .timeout     (t_timeout),
    .cycle_count (t_cc),
    .exit_code   (t_exit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    pc = pc + 32'd4;
    step();
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    pc        = '0;
    instr     = NOP;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Reset state, with start held during reset
    step();
    chk("rst core_rst_n", m_core_rst_n, 0);
    chk("rst running",    m_running,    0);
    chk("rst done",       m_done,       0);
    chk("rst pass",       m_pass,       0);
    chk("rst fail",       m_fail,       0);
    chk("rst timeout",    m_timeout,    0);
    chk("rst cc",         m_cc,         0);
    chk("rst exit",       m_exit,       0);
    step();
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk("idle after rst core_rst_n", m_core_rst_n, 0);
    chk("idle after rst running",    m_running,    0);

    // Launch: core_rst_n low for two cycles, then RUN
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hold1 core_rst_n", m_core_rst_n, 0);
    step();
    chk("hold2 core_rst_n", m_core_rst_n, 0);
    chk("hold2 running",    m_running,    0);
    step();
    chk("run entry core_rst_n", m_core_rst_n, 1);
    chk("run entry running",    m_running,    1);
    chk("run entry cc",         m_cc,         0);
    step();
    chk("first run edge cc", m_cc, 1);

    // tohost pass write at cycle 20
    repeat (19) tick();
    chk("cc at 20", m_cc, 20);
    mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'h1;
    step();
    mem_we = 1'b0;
    chk("tohost1 done",       m_done,       1);
    chk("tohost1 pass",       m_pass,       1);
    chk("tohost1 fail",       m_fail,       0);
    chk("tohost1 exit",       m_exit,       1);
    chk("tohost1 cc",         m_cc,         20);
    chk("tohost1 core_rst_n", m_core_rst_n, 0);
    chk("tohost1 running",    m_running,    0);
    step();
    chk("done hold cc",   m_cc,   20);
    chk("done hold done", m_done, 1);

    // Relaunch from DONE with start also held in RESET_HOLD
    start = 1'b1;
    step();
    chk("relaunch done cleared", m_done, 0);
    chk("relaunch pass cleared", m_pass, 0);
    chk("relaunch exit cleared", m_exit, 0);
    step();
    start = 1'b0;
    step();
    chk("relaunch running", m_running, 1);
    chk("relaunch cc",      m_cc,      0);

    // tohost 7 and ecall together: tohost wins
    repeat (4) tick();
    chk("cc at 4", m_cc, 4);
    mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'h7; instr = ECALL;
    step();
    mem_we = 1'b0; instr = NOP;
    chk("tohost7 fail", m_fail, 1);
    chk("tohost7 pass", m_pass, 0);
    chk("tohost7 exit", m_exit, 7);
    chk("tohost7 done", m_done, 1);
    chk("tohost7 cc",   m_cc,   4);

    // Write to another address is ignored; then ecall terminates
    launch();
    repeat (2) tick();
    mem_we = 1'b1; mem_addr = 32'h0000_0FF8; mem_wdata = 32'h1;
    tick();
    mem_we = 1'b0;
    chk("other addr running", m_running, 1);
    chk("other addr cc",      m_cc,      3);
    instr = ECALL;
    step();
    instr = NOP;
    chk("ecall pass", m_pass, 1);
    chk("ecall fail", m_fail, 0);
    chk("ecall exit", m_exit, 0);
    chk("ecall cc",   m_cc,   3);

    // Self-loop: pc held at 0x40 from cycle 10
    pc = 32'h0000_1000;
    launch();
    repeat (10) tick();
    chk("loop cc at 10", m_cc, 10);
    pc = 32'h0000_0040;
    repeat (4) step();
    chk("loop not yet done", m_done, 0);
    chk("loop cc 14",        m_cc,   14);
    step();
    chk("loop done", m_done, 1);
    chk("loop pass", m_pass, 1);
    chk("loop fail", m_fail, 0);
    chk("loop exit", m_exit, 0);
    chk("loop cc",   m_cc,   14);

    // Timeout with MAX_CYCLES=16
    launch();
    for (int i = 0; i < 40; i++) begin
      if (t_done) break;
      tick();
    end
    chk("to done",    t_done,    1);
    chk("to timeout", t_timeout, 1);
    chk("to fail",    t_fail,    1);
    chk("to pass",    t_pass,    0);
    chk("to cc",      t_cc,      15);
    chk("main no timeout", m_timeout, 0);
    chk("main still running", m_running, 1);
    chk("main cc 16", m_cc, 16);
    instr = ECALL;
    step();
    instr = NOP;
    chk("main ecall done", m_done, 1);

    // start ignored in RUN, then reset mid-RUN at cycle 5
    launch();
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start in run running", m_running, 1);
    chk("start in run cc",      m_cc,      3);
    repeat (2) tick();
    chk("cc at 5", m_cc, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun rst core_rst_n", m_core_rst_n, 0);
    chk("midrun rst running",    m_running,    0);
    chk("midrun rst done",       m_done,       0);
    chk("midrun rst pass",       m_pass,       0);
    chk("midrun rst fail",       m_fail,       0);
    chk("midrun rst timeout",    m_timeout,    0);
    chk("midrun rst cc",         m_cc,         0);
    chk("midrun rst exit",       m_exit,       0);
    step();
    rst = 1'b0;
    step();
    chk("post rst idle running", m_running, 0);
    chk("post rst idle cc",      m_cc,      0);
    launch();
    chk("post rst launch running", m_running, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
